fwd_hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed two-stage, two-operand forwarding logic.
- Owns a shift-register model of the post-EX pipeline stages, tracking rd, reg_write and is_load per stage.
- Each cycle it produces per-operand forwarding selects for the instruction in EX, plus a load-use / no-forward stall request for the instruction in ID.
- Sits beside the ID/EX pipeline register. Drives the EX operand muxes and the IF/ID hold and ID/EX bubble control.

---
 rtl/fwd_hazard_scoreboard.sv | 132 +++++++++++++
 tb/tb_fwd_hazard_scoreboard.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_scoreboard
// Purpose  : Tracks post-EX writers and produces EX forwarding selects plus
//            the load-use / no-forward stall request for the ID instruction.
// Revision : 1.0
// ============================================================================
module fwd_hazard_scoreboard #(
    parameter int NUM_SRC          = 2,
    parameter int NUM_FWD_STAGES   = 2,
    parameter int REG_ADDR_W       = 5,
    parameter int LOAD_READY_STAGE = 1,
    parameter int FWD_ENABLE       = 1,
    parameter int SEL_W            = $clog2(NUM_FWD_STAGES + 1),
    parameter int CNT_W            = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ex_valid,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic                          ex_reg_write,
    input  logic                          ex_is_load,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic                          id_valid,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          stall,
    output logic [CNT_W-1:0]              stall_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic                  r_valid     [NUM_FWD_STAGES];
    logic [REG_ADDR_W-1:0] r_rd        [NUM_FWD_STAGES];
    logic                  r_reg_write [NUM_FWD_STAGES];
    logic                  r_is_load   [NUM_FWD_STAGES];
    logic [CNT_W-1:0]      r_stall_count;

    logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
    logic                     w_stall;
    logic [REG_ADDR_W-1:0]    w_ex_src;
    logic [REG_ADDR_W-1:0]    w_id_src;

    // x0 is hardwired to zero, so it never counts as a real write.
    function automatic logic writes_reg(input logic v, input logic rw,
                                        input logic [REG_ADDR_W-1:0] rd,
                                        input logic [REG_ADDR_W-1:0] r);
        return v && rw && (rd == r) && (r != '0);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_FWD_STAGES; k++) begin
                r_valid[k]     <= 1'b0;
                r_rd[k]        <= '0;
                r_reg_write[k] <= 1'b0;
                r_is_load[k]   <= 1'b0;
            end
        end else begin
            r_valid[0]     <= ex_valid;
            r_rd[0]        <= ex_rd;
            r_reg_write[0] <= ex_reg_write;
            r_is_load[0]   <= ex_is_load;
            for (int k = 1; k < NUM_FWD_STAGES; k++) begin
                r_valid[k]     <= r_valid[k-1];
                r_rd[k]        <= r_rd[k-1];
                r_reg_write[k] <= r_reg_write[k-1];
                r_is_load[k]   <= r_is_load[k-1];
            end
        end
    end

    // Scan oldest to youngest so the youngest matching writer is the last to land.
    always_comb begin
        w_fwd_sel = '0;
        w_ex_src  = '0;
        if (FWD_ENABLE != 0) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                w_ex_src = ex_rs[i*REG_ADDR_W +: REG_ADDR_W];
                for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
                    if (writes_reg(r_valid[k], r_reg_write[k], r_rd[k], w_ex_src))
                        w_fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
        end
    end

    // EX slot is position -1, so its readiness test uses 0 < threshold.
    always_comb begin
        w_stall  = 1'b0;
        w_id_src = '0;
        if (id_valid) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                w_id_src = id_rs[i*REG_ADDR_W +: REG_ADDR_W];
                if (id_rs_used[i]) begin
                    if (FWD_ENABLE != 0) begin
                        if (writes_reg(ex_valid, ex_reg_write, ex_rd, w_id_src) &&
                            ex_is_load && (LOAD_READY_STAGE > 0))
                            w_stall = 1'b1;
                        for (int k = 0; k < NUM_FWD_STAGES; k++) begin
                            if (writes_reg(r_valid[k], r_reg_write[k], r_rd[k], w_id_src) &&
                                r_is_load[k] && (k + 1 < LOAD_READY_STAGE))
                                w_stall = 1'b1;
                        end
                    end else begin
                        if (writes_reg(ex_valid, ex_reg_write, ex_rd, w_id_src))
                            w_stall = 1'b1;
                        for (int k = 0; k < NUM_FWD_STAGES; k++) begin
                            if (writes_reg(r_valid[k], r_reg_write[k], r_rd[k], w_id_src) &&
                                (k + 1 < NUM_FWD_STAGES))
                                w_stall = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_stall_count <= '0;
        else if (w_stall && (r_stall_count != c_cnt_max))
            r_stall_count <= r_stall_count + CNT_W'(1);
    end

    assign fwd_sel     = w_fwd_sel;
    assign stall       = w_stall;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_scoreboard
// Purpose  : Directed vector table plus multi-cycle sequences for three
//            parameterisations of the forwarding/hazard scoreboard.
// Revision : 1.0
// ============================================================================
module tb_fwd_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_is_load;
    logic [9:0] ex_rs;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic       id_valid;

    logic [3:0]  sel_d,  sel_lr,  sel_nf;
    logic        stall_d, stall_lr, stall_nf;
    logic [31:0] cnt_d,  cnt_lr;
    logic [1:0]  cnt_nf;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fwd_hazard_scoreboard dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rs(ex_rs),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_valid(id_valid),
        .fwd_sel(sel_d), .stall(stall_d), .stall_count(cnt_d)
    );

    fwd_hazard_scoreboard #(.NUM_FWD_STAGES(3), .LOAD_READY_STAGE(2)) dut_lr (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rs(ex_rs),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_valid(id_valid),
        .fwd_sel(sel_lr), .stall(stall_lr), .stall_count(cnt_lr)
    );

    fwd_hazard_scoreboard #(.FWD_ENABLE(0), .CNT_W(2)) dut_nf (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_rs(ex_rs),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_valid(id_valid),
        .fwd_sel(sel_nf), .stall(stall_nf), .stall_count(cnt_nf)
    );

    typedef struct {
        logic       ev;
        logic [4:0] erd;
        logic       erw;
        logic       eld;
        logic [4:0] ers0, ers1;
        logic [4:0] irs0, irs1;
        logic [1:0] iused;
        logic       iv;
        logic [1:0] sel0, sel1;
        logic       stl;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic ev, logic [4:0] erd, logic erw, logic eld,
                                logic [4:0] ers0, logic [4:0] ers1,
                                logic [4:0] irs0, logic [4:0] irs1,
                                logic [1:0] iused, logic iv,
                                logic [1:0] sel0, logic [1:0] sel1, logic stl);
        vec_t v;
        v.ev = ev; v.erd = erd; v.erw = erw; v.eld = eld;
        v.ers0 = ers0; v.ers1 = ers1; v.irs0 = irs0; v.irs1 = irs1;
        v.iused = iused; v.iv = iv; v.sel0 = sel0; v.sel1 = sel1; v.stl = stl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [4:0] erd, input logic erw,
                         input logic eld, input logic [4:0] ers0, input logic [4:0] ers1,
                         input logic [4:0] irs0, input logic [4:0] irs1,
                         input logic [1:0] iused, input logic iv);
        ex_valid = ev; ex_rd = erd; ex_reg_write = erw; ex_is_load = eld;
        ex_rs = {ers1, ers0}; id_rs = {irs1, irs0}; id_rs_used = iused; id_valid = iv;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();

        //      ev erd rw ld ers0 ers1 irs0 irs1 used  iv  sel0 sel1 stall
        vq.push_back(mk(1, 5, 1, 0,  0,  0,  0,  0, 2'b00, 0, 0, 0, 0)); // add x5
        vq.push_back(mk(0, 0, 0, 0,  5,  0,  0,  0, 2'b00, 0, 1, 0, 0)); // x5 from EX/MEM
        vq.push_back(mk(0, 0, 0, 0,  5,  0,  0,  0, 2'b00, 0, 2, 0, 0)); // x5 from MEM/WB
        vq.push_back(mk(0, 0, 0, 0,  5,  0,  0,  0, 2'b00, 0, 0, 0, 0)); // retired
        vq.push_back(mk(1, 5, 1, 0,  0,  0,  0,  0, 2'b00, 0, 0, 0, 0));
        vq.push_back(mk(1, 5, 1, 0,  0,  5,  0,  0, 2'b00, 0, 0, 1, 0)); // back-to-back x5
        vq.push_back(mk(0, 0, 0, 0,  5,  5,  0,  0, 2'b00, 0, 1, 1, 0)); // youngest wins
        vq.push_back(mk(1, 7, 1, 1,  5,  0,  7,  3, 2'b01, 1, 2, 0, 1)); // load-use stall
        vq.push_back(mk(1, 7, 1, 1,  0,  7,  7,  3, 2'b00, 1, 0, 1, 0)); // source unused
        vq.push_back(mk(1, 7, 1, 1,  0,  0,  7,  7, 2'b10, 0, 0, 0, 0)); // ID bubble
        vq.push_back(mk(1, 7, 1, 1,  0,  0,  7,  7, 2'b10, 1, 0, 0, 1)); // operand 1 stall
        vq.push_back(mk(1, 0, 1, 1,  0,  0,  0,  0, 2'b01, 1, 0, 0, 0)); // load x0
        vq.push_back(mk(0, 0, 0, 0,  0,  7,  0,  0, 2'b00, 0, 0, 2, 0)); // x0 not forwarded
        vq.push_back(mk(1, 6, 0, 0,  0,  0,  6,  0, 2'b01, 1, 0, 0, 0)); // no reg_write
        vq.push_back(mk(0, 0, 0, 0,  6,  0,  0,  0, 2'b00, 0, 0, 0, 0));
        vq.push_back(mk(0, 5, 1, 0,  0,  0,  0,  0, 2'b00, 0, 0, 0, 0)); // invalid writer
        vq.push_back(mk(0, 0, 0, 0,  5,  0,  0,  0, 2'b00, 0, 0, 0, 0));
        vq.push_back(mk(1, 8, 1, 1,  0,  0,  0,  0, 2'b00, 0, 0, 0, 0)); // load x8
        vq.push_back(mk(0, 0, 0, 0,  8,  0,  8,  0, 2'b01, 1, 1, 0, 0)); // ready at stage 0

        next_cycle();
        #2;
        chk("reset_sel",   {28'd0, sel_d}, 32'd0);
        chk("reset_stall", {31'd0, stall_d}, 32'd0);
        chk("reset_count", cnt_d, 32'd0);
        next_cycle();
        reset = 1'b0;

        foreach (vq[j]) begin
            drive(vq[j].ev, vq[j].erd, vq[j].erw, vq[j].eld, vq[j].ers0, vq[j].ers1,
                  vq[j].irs0, vq[j].irs1, vq[j].iused, vq[j].iv);
            #2;
            chk($sformatf("vec%0d_sel", j), {28'd0, sel_d}, {28'd0, vq[j].sel1, vq[j].sel0});
            chk($sformatf("vec%0d_stall", j), {31'd0, stall_d}, {31'd0, vq[j].stl});
            next_cycle();
        end
        idle();
        #2;
        chk("table_stall_count", cnt_d, 32'd2);

        // Late load readiness: NUM_FWD_STAGES=3, LOAD_READY_STAGE=2.
        do_reset();
        drive(1, 9, 1, 1, 0, 0, 9, 0, 2'b01, 1);
        #2; chk("lr_ex_stall", {31'd0, stall_lr}, 32'd1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 9, 0, 2'b01, 1);
        #2; chk("lr_e0_stall", {31'd0, stall_lr}, 32'd1);
        next_cycle();
        drive(0, 0, 0, 0, 9, 0, 9, 0, 2'b01, 1);
        #2; chk("lr_e1_stall", {31'd0, stall_lr}, 32'd0);
        chk("lr_e1_sel", {28'd0, sel_lr}, 32'd2);
        next_cycle();
        drive(0, 0, 0, 0, 9, 0, 0, 0, 2'b00, 0);
        #2; chk("lr_e2_sel", {28'd0, sel_lr}, 32'd3);
        chk("lr_count", cnt_lr, 32'd2);
        next_cycle();

        // No-forward mode with a 2-bit saturating counter.
        do_reset();
        drive(1, 4, 1, 0, 4, 0, 4, 0, 2'b01, 1);
        #2; chk("nf_ex_stall", {31'd0, stall_nf}, 32'd1);
        chk("nf_ex_sel", {28'd0, sel_nf}, 32'd0);
        next_cycle();
        drive(0, 0, 0, 0, 4, 0, 4, 0, 2'b01, 1);
        #2; chk("nf_e0_stall", {31'd0, stall_nf}, 32'd1);
        chk("nf_e0_sel", {28'd0, sel_nf}, 32'd0);
        next_cycle();
        #2; chk("nf_e1_stall", {31'd0, stall_nf}, 32'd0);
        chk("nf_e1_sel", {28'd0, sel_nf}, 32'd0);
        chk("nf_count", {30'd0, cnt_nf}, 32'd2);
        drive(1, 4, 1, 0, 0, 0, 4, 0, 2'b01, 1);
        for (int c = 0; c < 4; c++) next_cycle();
        idle();
        #2; chk("nf_count_sat", {30'd0, cnt_nf}, 32'd3);
        next_cycle();

        // Reset mid-stream drops the in-flight x5 writer and the stall count.
        drive(1, 7, 1, 1, 0, 0, 7, 0, 2'b01, 1);
        next_cycle();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 2'b00, 0);
        next_cycle();
        idle();
        reset = 1'b1;
        #2; chk("pre_reset_count", {31'd0, cnt_d != 32'd0}, 32'd1);
        next_cycle();
        reset = 1'b0;
        drive(0, 0, 0, 0, 5, 0, 0, 0, 2'b00, 0);
        #2; chk("post_reset_sel", {28'd0, sel_d}, 32'd0);
        chk("post_reset_count", cnt_d, 32'd0);
        next_cycle();

        // Writes to x0 through every stage.
        drive(1, 0, 1, 0, 0, 0, 0, 0, 2'b11, 1);
        #2; chk("x0_ex_stall_nf", {31'd0, stall_nf}, 32'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1);
        #2; chk("x0_e0_sel", {28'd0, sel_d}, 32'd0);
        chk("x0_e0_stall_nf", {31'd0, stall_nf}, 32'd0);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
